banked_mem_resp: RTL and testbench

- Four-bank, word-interleaved main-memory responder.
- It is the memory-side end of the interface that the cache controller FSM drives with fm_addr, fm_data_in, fm_wr and fm_rd.
- It accepts one 16-bit word request per cycle and returns read data after a fixed 2-cycle latency.
- Each bank has a per-bank busy window, so a controller can stream bank 0 through bank 3 back-to-back to fill a 4-word line.

---
 rtl/banked_mem_resp.sv | 92 +++++++++
 tb/tb_banked_mem_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_resp.sv
// Four-bank, word-interleaved memory responder with per-bank busy windows.
// Reads return two cycles after acceptance; writes land at the accept edge.
module banked_mem_resp #(
    parameter int LINE_BITS   = 8,
    parameter int BANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int         DEPTH = 1 << LINE_BITS;
    localparam logic [2:0] LOAD  = 3'(BANK_CYCLES - 1);

    logic [1:0]           bank;
    logic [LINE_BITS-1:0] row;
    logic [LINE_BITS+1:0] idx;
    logic                 req_ok;
    logic                 accept;
    logic [3:0][2:0]      cnt;
    logic [15:0]          mem [4*DEPTH];
    logic                 s1_valid;
    logic [15:0]          s1_data;

    assign bank   = addr[2:1];
    assign row    = addr[LINE_BITS+2:3];
    assign idx    = {bank, row};
    assign req_ok = (rd ^ wr) & ~addr[0];
    assign err    = (rd & wr) | ((rd | wr) & addr[0]);
    assign stall  = req_ok & busy[bank];
    assign accept = req_ok & ~busy[bank];

    // High address bits alias onto the same row.
    generate
        if (LINE_BITS + 3 <= 15) begin : g_alias
            logic unused_high;
            assign unused_high = ^addr[15:LINE_BITS+3];
        end
    endgenerate

    always_comb begin
        busy = '0;
        for (int i = 0; i < 4; i++) begin
            busy[i] = (cnt[i] != 3'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (bank == 2'(i))) begin
                    cnt[i] <= LOAD;
                end else if (cnt[i] != 3'd0) begin
                    cnt[i] <= cnt[i] - 3'd1;
                end
            end
        end
    end

    // Array and stage-1 data are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[idx] <= data_in;
        end
        if (accept && rd) begin
            s1_data <= mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else begin
            s1_valid   <= accept & rd;
            data_valid <= s1_valid;
            data_out   <= s1_valid ? s1_data : 16'h0000;
        end
    end

endmodule

// File: tb/tb_banked_mem_resp.sv
// Directed bench for banked_mem_resp: a cycle-based behavioural model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_banked_mem_resp;

    localparam int BANK_CYCLES = 4;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int check_count = 0;
    int pass_count  = 0;

    banked_mem_resp #(.LINE_BITS(8), .BANK_CYCLES(BANK_CYCLES)) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .data_in(data_in),
        .wr(wr),
        .rd(rd),
        .data_out(data_out),
        .data_valid(data_valid),
        .stall(stall),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Model: a bank is busy while the cycle number is below its free time;
    // accepted reads schedule their word for the cycle two ahead.
    int          cyc = 0;
    int          free_at [4];
    logic [15:0] mdl_mem [4][256];
    logic        ret_v   [8];
    logic [15:0] ret_d   [8];

    initial begin
        for (int i = 0; i < 4; i++) begin
            free_at[i] = 0;
            for (int j = 0; j < 256; j++) mdl_mem[i][j] = 16'h0000;
        end
        for (int i = 0; i < 8; i++) begin
            ret_v[i] = 1'b0;
            ret_d[i] = 16'h0000;
        end
    end

    always @(negedge clk) begin
        int          b;
        int          r;
        bit          ok;
        bit          e;
        logic [3:0]  eb;
        logic [15:0] ed;
        if (rst) begin
            for (int i = 0; i < 4; i++) free_at[i] = 0;
            for (int i = 0; i < 8; i++) ret_v[i] = 1'b0;
            checkOutput("mdl_rst_busy", 16'(busy), 16'h0000);
            checkOutput("mdl_rst_valid", 16'(data_valid), 16'h0000);
            checkOutput("mdl_rst_data", data_out, 16'h0000);
        end else begin
            b  = (int'(addr) / 2) % 4;
            r  = (int'(addr) / 8) % 256;
            ok = (rd != wr) && (addr % 2 == 0);
            e  = (rd && wr) || ((rd || wr) && (addr % 2 == 1));
            for (int i = 0; i < 4; i++) eb[i] = (cyc < free_at[i]);
            ed = ret_v[cyc % 8] ? ret_d[cyc % 8] : 16'h0000;
            checkOutput("mdl_err", 16'(err), 16'(e));
            checkOutput("mdl_stall", 16'(stall), 16'(ok && eb[b]));
            checkOutput("mdl_busy", 16'(busy), 16'(eb));
            checkOutput("mdl_valid", 16'(data_valid), 16'(ret_v[cyc % 8]));
            checkOutput("mdl_data", data_out, ed);
            ret_v[cyc % 8] = 1'b0;
            if (ok && !eb[b]) begin
                free_at[b] = cyc + BANK_CYCLES;
                if (wr) begin
                    mdl_mem[b][r] = data_in;
                end else begin
                    ret_v[(cyc + 2) % 8] = 1'b1;
                    ret_d[(cyc + 2) % 8] = mdl_mem[b][r];
                end
            end
        end
        cyc++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("reset_busy", 16'(busy), 16'h0000);
        checkOutput("reset_valid", 16'(data_valid), 16'h0000);
        checkOutput("reset_data", data_out, 16'h0000);

        // Single write then read-back.
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hA5A5);
        checkOutput("t1_wr_stall", 16'(stall), 16'h0000);
        checkOutput("t1_wr_err", 16'(err), 16'h0000);
        repeat (3) idle();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        checkOutput("t1_rd_stall", 16'(stall), 16'h0000);
        checkOutput("t1_rd_busy", 16'(busy), 16'h0000);
        idle();
        checkOutput("t1_busy_t1", 16'(busy), 16'h0001);
        checkOutput("t1_valid_t1", 16'(data_valid), 16'h0000);
        idle();
        checkOutput("t1_valid_t2", 16'(data_valid), 16'h0001);
        checkOutput("t1_data_t2", data_out, 16'hA5A5);
        idle();
        checkOutput("t1_valid_t3", 16'(data_valid), 16'h0000);
        checkOutput("t1_data_t3", data_out, 16'h0000);

        // Line-fill burst across all four banks.
        applyStimulus(1'b0, 1'b1, 16'h0100, 16'h1111);
        applyStimulus(1'b0, 1'b1, 16'h0102, 16'h2222);
        applyStimulus(1'b0, 1'b1, 16'h0104, 16'h3333);
        applyStimulus(1'b0, 1'b1, 16'h0106, 16'h4444);
        repeat (4) idle();
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000);
        checkOutput("t2_busy_t0", 16'(busy), 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0102, 16'h0000);
        checkOutput("t2_busy_t1", 16'(busy), 16'h0001);
        checkOutput("t2_stall_t1", 16'(stall), 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0104, 16'h0000);
        checkOutput("t2_busy_t2", 16'(busy), 16'h0003);
        checkOutput("t2_data_t2", data_out, 16'h1111);
        applyStimulus(1'b1, 1'b0, 16'h0106, 16'h0000);
        checkOutput("t2_busy_t3", 16'(busy), 16'h0007);
        checkOutput("t2_stall_t3", 16'(stall), 16'h0000);
        checkOutput("t2_data_t3", data_out, 16'h2222);
        idle();
        checkOutput("t2_busy_t4", 16'(busy), 16'h000E);
        checkOutput("t2_data_t4", data_out, 16'h3333);
        idle();
        checkOutput("t2_data_t5", data_out, 16'h4444);
        checkOutput("t2_valid_t5", 16'(data_valid), 16'h0001);
        idle();
        checkOutput("t2_valid_t6", 16'(data_valid), 16'h0000);

        // Bank conflict on bank 0.
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h1234);
        repeat (3) idle();
        applyStimulus(1'b0, 1'b1, 16'h0008, 16'h5678);
        repeat (3) idle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
        checkOutput("t3_stall_t0", 16'(stall), 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        checkOutput("t3_stall_t1", 16'(stall), 16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        checkOutput("t3_stall_t2", 16'(stall), 16'h0001);
        checkOutput("t3_data_t2", data_out, 16'h1234);
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        checkOutput("t3_stall_t3", 16'(stall), 16'h0001);
        checkOutput("t3_valid_t3", 16'(data_valid), 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        checkOutput("t3_stall_t4", 16'(stall), 16'h0000);
        idle();
        checkOutput("t3_valid_t5", 16'(data_valid), 16'h0000);
        idle();
        checkOutput("t3_valid_t6", 16'(data_valid), 16'h0001);
        checkOutput("t3_data_t6", data_out, 16'h5678);

        // Illegal requests: no side effects.
        repeat (3) idle();
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h9999);
        checkOutput("t4_both_err", 16'(err), 16'h0001);
        checkOutput("t4_both_stall", 16'(stall), 16'h0000);
        idle();
        checkOutput("t4_both_busy", 16'(busy), 16'h0000);
        idle();
        checkOutput("t4_both_valid", 16'(data_valid), 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0021, 16'h0000);
        checkOutput("t4_odd_err", 16'(err), 16'h0001);
        checkOutput("t4_odd_stall", 16'(stall), 16'h0000);
        idle();
        checkOutput("t4_odd_busy", 16'(busy), 16'h0000);
        idle();
        checkOutput("t4_odd_valid", 16'(data_valid), 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0023, 16'hFFFF);
        checkOutput("t4_oddwr_err", 16'(err), 16'h0001);

        // Reset asserted while a read is in flight.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1; rd = 1'b0;
        #1;
        checkOutput("t5_rst_busy", 16'(busy), 16'h0000);
        checkOutput("t5_rst_valid", 16'(data_valid), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t5_t2_valid", 16'(data_valid), 16'h0000);
        checkOutput("t5_t2_busy", 16'(busy), 16'h0000);
        idle();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle();
        idle();
        checkOutput("t5_readback", data_out, 16'hA5A5);

        // High address bits alias.
        repeat (2) idle();
        applyStimulus(1'b0, 1'b1, 16'h0808, 16'hBEEF);
        repeat (3) idle();
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        idle();
        idle();
        checkOutput("t6_alias_valid", 16'(data_valid), 16'h0001);
        checkOutput("t6_alias_data", data_out, 16'hBEEF);
        repeat (3) idle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
